// File: rtl/output_vc_state_pkg.sv
// Shared types and helpers for the output-VC allocation and credit tracking block.
package output_vc_state_pkg;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_ACTIVE = 2'd1,
        VC_DRAIN  = 2'd2
    } vcState_t;

    // Ceiling log2; a credit counter needs CLogB2(depth)+1 bits to hold the full depth.
    function automatic int CLogB2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int numVcs(input int vcWidth);
        return 1 << vcWidth;
    endfunction

endpackage

// File: rtl/output_vc_slice.sv
// One output VC: IDLE/ACTIVE/DRAIN state plus a saturating downstream credit counter.
module output_vc_slice
    import output_vc_state_pkg::*;
#(
    parameter int NCREDITS     = 4,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic i_grant,
    input  logic i_send,
    input  logic i_tail,
    input  logic i_credit,
    output logic o_idle,
    output logic o_creditAvail,
    output logic o_protoErr
);

    localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(NCREDITS);

    vcState_t                r_state;
    vcState_t                w_stateNext;
    logic [CREDIT_WIDTH-1:0] r_count;
    logic [CREDIT_WIDTH-1:0] w_countNext;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= VC_IDLE;
            r_count <= FULL;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    // A send and a credit in the same cycle cancel; lone updates saturate at 0 and FULL.
    always_comb begin
        w_countNext = r_count;
        if (i_send && !i_credit) begin
            if (r_count != '0) begin
                w_countNext = r_count - 1'b1;
            end
        end else if (i_credit && !i_send) begin
            if (r_count != FULL) begin
                w_countNext = r_count + 1'b1;
            end
        end

        w_stateNext = r_state;
        case (r_state)
            VC_IDLE: begin
                if (i_grant) begin
                    w_stateNext = VC_ACTIVE;
                end
            end
            VC_ACTIVE: begin
                if (i_send && i_tail) begin
                    w_stateNext = (w_countNext == FULL) ? VC_IDLE : VC_DRAIN;
                end
            end
            VC_DRAIN: begin
                if (w_countNext == FULL) begin
                    w_stateNext = VC_IDLE;
                end
            end
            default: w_stateNext = VC_IDLE;
        endcase
    end

    always_comb begin
        o_idle        = (r_state == VC_IDLE);
        o_creditAvail = (r_count != '0);
        o_protoErr    = (i_send && ((r_state != VC_ACTIVE) || (r_count == '0)))
                      || (i_credit && (r_count == FULL));
    end

endmodule

// File: rtl/output_vc_state.sv
// Output-VC state tracker: round-robin allocation of idle VCs, per-VC credit slices, sticky error.
module output_vc_state
    import output_vc_state_pkg::*;
#(
    parameter int VC_WIDTH = 1,
    parameter int NCREDITS = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alloc_req,
    output logic                       alloc_grant,
    output logic [VC_WIDTH-1:0]        allocated_vc,
    input  logic                       flit_send,
    input  logic [VC_WIDTH-1:0]        flit_vc,
    input  logic                       flit_tail,
    input  logic                       credit_valid,
    input  logic [VC_WIDTH-1:0]        credit_vc,
    output logic [(1<<VC_WIDTH)-1:0]   vc_idle,
    output logic [(1<<VC_WIDTH)-1:0]   vc_credit_avail,
    output logic                       error
);

    localparam int NVCS         = numVcs(VC_WIDTH);
    localparam int CREDIT_WIDTH = CLogB2(NCREDITS) + 1;

    logic [VC_WIDTH-1:0] r_ptr;
    logic                r_error;
    logic [NVCS-1:0]     w_idle;
    logic [NVCS-1:0]     w_creditAvail;
    logic [NVCS-1:0]     w_protoErr;
    logic [NVCS-1:0]     w_grantVec;
    logic [VC_WIDTH-1:0] w_sel;
    logic [VC_WIDTH-1:0] w_idx;
    logic                w_anyIdle;

    // Scan from the pointer upward; VC_WIDTH-bit addition gives the wrap to VC 0 for free.
    always_comb begin
        w_anyIdle = 1'b0;
        w_sel     = '0;
        w_idx     = '0;
        for (int k = 0; k < NVCS; k++) begin
            w_idx = r_ptr + VC_WIDTH'(k);
            if (!w_anyIdle && w_idle[w_idx]) begin
                w_anyIdle = 1'b1;
                w_sel     = w_idx;
            end
        end
    end

    assign alloc_grant  = alloc_req && w_anyIdle;
    assign allocated_vc = w_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr   <= '0;
            r_error <= 1'b0;
        end else begin
            if (alloc_grant) begin
                r_ptr <= w_sel + 1'b1;
            end
            if (|w_protoErr) begin
                r_error <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NVCS; g++) begin : gSlice
        assign w_grantVec[g] = alloc_grant && (w_sel == VC_WIDTH'(g));

        output_vc_slice #(
            .NCREDITS     (NCREDITS),
            .CREDIT_WIDTH (CREDIT_WIDTH)
        ) uSlice (
            .clock         (clock),
            .reset         (reset),
            .i_grant       (w_grantVec[g]),
            .i_send        (flit_send && (flit_vc == VC_WIDTH'(g))),
            .i_tail        (flit_tail),
            .i_credit      (credit_valid && (credit_vc == VC_WIDTH'(g))),
            .o_idle        (w_idle[g]),
            .o_creditAvail (w_creditAvail[g]),
            .o_protoErr    (w_protoErr[g])
        );
    end

    assign vc_idle         = w_idle;
    assign vc_credit_avail = w_creditAvail;
    assign error           = r_error;

endmodule

// File: tb/tb_output_vc_state.sv
// Directed scenarios followed by random traffic, checked against a per-VC behavioural model.
module tb_output_vc_state;

    localparam int VC_WIDTH = 1;
    localparam int NCREDITS = 4;
    localparam int NVCS     = 1 << VC_WIDTH;
    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DRAIN  = 2;

    logic                clock;
    logic                reset;
    logic                alloc_req;
    logic                alloc_grant;
    logic [VC_WIDTH-1:0] allocated_vc;
    logic                flit_send;
    logic [VC_WIDTH-1:0] flit_vc;
    logic                flit_tail;
    logic                credit_valid;
    logic [VC_WIDTH-1:0] credit_vc;
    logic [NVCS-1:0]     vc_idle;
    logic [NVCS-1:0]     vc_credit_avail;
    logic                error;

    int checks   = 0;
    int failures = 0;

    int mState[NVCS];
    int mCount[NVCS];
    int mPtr;
    bit mErr;

    output_vc_state #(
        .VC_WIDTH (VC_WIDTH),
        .NCREDITS (NCREDITS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_grant     (alloc_grant),
        .allocated_vc    (allocated_vc),
        .flit_send       (flit_send),
        .flit_vc         (flit_vc),
        .flit_tail       (flit_tail),
        .credit_valid    (credit_valid),
        .credit_vc       (credit_vc),
        .vc_idle         (vc_idle),
        .vc_credit_avail (vc_credit_avail),
        .error           (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int firstIdle();
        for (int k = 0; k < NVCS; k++) begin
            if (mState[(mPtr + k) % NVCS] == M_IDLE) return (mPtr + k) % NVCS;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int v = 0; v < NVCS; v++) begin
            mState[v] = M_IDLE;
            mCount[v] = NCREDITS;
        end
        mPtr = 0;
        mErr = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic modelUpdate();
        int sel;
        int newCount;
        bit s;
        bit c;
        if (reset) begin
            modelReset();
            return;
        end
        sel = alloc_req ? firstIdle() : -1;
        for (int v = 0; v < NVCS; v++) begin
            s = flit_send && (int'(flit_vc) == v);
            c = credit_valid && (int'(credit_vc) == v);
            if (s && (mState[v] != M_ACTIVE || mCount[v] == 0)) mErr = 1'b1;
            if (c && mCount[v] == NCREDITS) mErr = 1'b1;
            newCount = mCount[v];
            if (s && !c) newCount = (mCount[v] > 0) ? mCount[v] - 1 : 0;
            if (c && !s) newCount = (mCount[v] < NCREDITS) ? mCount[v] + 1 : NCREDITS;
            if (mState[v] == M_IDLE && sel == v) begin
                mState[v] = M_ACTIVE;
            end else if (mState[v] == M_ACTIVE && s && flit_tail) begin
                mState[v] = (newCount == NCREDITS) ? M_IDLE : M_DRAIN;
            end else if (mState[v] == M_DRAIN && newCount == NCREDITS) begin
                mState[v] = M_IDLE;
            end
            mCount[v] = newCount;
        end
        if (sel >= 0) mPtr = (sel + 1) % NVCS;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkOutput();
        int sel;
        logic [NVCS-1:0] expIdle;
        logic [NVCS-1:0] expAvail;
        sel = firstIdle();
        checkOne("alloc_grant", 32'(alloc_grant), 32'(alloc_req && (sel >= 0)));
        if (alloc_req && sel >= 0) checkOne("allocated_vc", 32'(allocated_vc), 32'(sel));
        for (int v = 0; v < NVCS; v++) begin
            expIdle[v]  = (mState[v] == M_IDLE);
            expAvail[v] = (mCount[v] > 0);
        end
        checkOne("vc_idle", 32'(vc_idle), 32'(expIdle));
        checkOne("vc_credit_avail", 32'(vc_credit_avail), 32'(expAvail));
        checkOne("error", 32'(error), 32'(mErr));
    endtask

    task automatic applyStimulus(input bit rst, input bit req, input bit send, input int vc,
                                 input bit tail, input bit cr, input int crvc);
        @(negedge clock);
        reset        = rst;
        alloc_req    = req;
        flit_send    = send;
        flit_vc      = VC_WIDTH'(vc);
        flit_tail    = tail;
        credit_valid = cr;
        credit_vc    = VC_WIDTH'(crvc);
        #1;
        checkOutput();
        @(posedge clock);
        modelUpdate();
    endtask

    initial begin
        reset = 1'b1; alloc_req = 1'b0; flit_send = 1'b0; flit_vc = '0;
        flit_tail = 1'b0; credit_valid = 1'b0; credit_vc = '0;
        repeat (2) @(posedge clock);
        modelReset();

        // Reset state, with grant following request while everything is idle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Three requests: VC0, VC1, then nothing left.
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Exhaust VC0 credits, then one send too many.
        repeat (4) applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Head + tail, then two credits drain VC0 back to idle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Tail and credit together at count 3.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Wrap-around: pointer at 1, VC1 busy, VC0 idle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Reset mid-packet with VC1 draining at count 1 and a sticky error set.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 1, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 9) < 4), int'($urandom_range(0, NVCS - 1)),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) < 4),
                          int'($urandom_range(0, NVCS - 1)));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_vc_state.md
OUTPUT_VC_STATE -- requirements
Module: output_vc_state

Interface
REQ-001 VC_WIDTH, 1, width of an output-VC index; NVCS = 1 << VC_WIDTH output VCs.
REQ-002 NCREDITS, 4, downstream buffer depth per VC; CREDIT_WIDTH = CLogB2(NCREDITS) + 1.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 alloc_req  input  1  head flit requests a free output VC.
REQ-006 alloc_grant  output  1  combinational; request granted this cycle.
REQ-007 allocated_vc  output  VC_WIDTH  combinational; granted VC index, valid when alloc_grant=1.
REQ-008 flit_send  input  1  a flit leaves on flit_vc this cycle.
REQ-009 flit_vc  input  VC_WIDTH  VC of the departing flit.
REQ-010 flit_tail  input  1  departing flit is a tail.
REQ-011 credit_valid  input  1  downstream returns one credit.
REQ-012 credit_vc  input  VC_WIDTH  VC of the returned credit.
REQ-013 vc_idle  output  NVCS  registered; bit i=1 when VC i is IDLE.
REQ-014 vc_credit_avail  output  NVCS  registered; bit i=1 when credit count of VC i > 0.
REQ-015 error  output  1  registered, sticky protocol-violation flag.

Function
REQ-016 Each VC SHALL hold a 3-state FSM: IDLE, ACTIVE, DRAIN, plus a CREDIT_WIDTH credit counter.
REQ-017 alloc_grant SHALL equal alloc_req AND (any VC IDLE), evaluated on current registered state.
REQ-018 allocated_vc SHALL be the first IDLE VC at or after the round-robin pointer, wrapping NVCS-1 -> 0.
REQ-019 On a grant the chosen VC SHALL go IDLE -> ACTIVE and the pointer SHALL become allocated_vc + 1 mod NVCS at the next edge.
REQ-020 No grant: pointer unchanged; alloc_req with no IDLE VC SHALL give alloc_grant=0, not an error.
REQ-021 flit_send SHALL decrement the credit count of flit_vc by 1.
REQ-022 credit_valid SHALL increment the credit count of credit_vc by 1.
REQ-023 Send and credit on the same VC in the same cycle SHALL leave its count unchanged.
REQ-024 flit_send with flit_tail on an ACTIVE VC SHALL move it to IDLE if the updated count equals NCREDITS, else to DRAIN.
REQ-025 A DRAIN VC SHALL move to IDLE in the cycle its updated count reaches NCREDITS.
REQ-026 A VC that becomes IDLE at an edge SHALL be grantable from the following cycle, never the same cycle.
REQ-027 error SHALL set on: send on a non-ACTIVE VC, send with count 0, credit with count NCREDITS; the offending count SHALL saturate (no wrap).
REQ-028 vc_idle and vc_credit_avail SHALL reflect state after the edge, with one cycle latency from the causing input.

Reset
REQ-029 On reset all VCs SHALL be IDLE, counts = NCREDITS, pointer = 0, error = 0.
REQ-030 Outputs after reset: vc_idle all ones, vc_credit_avail all ones; alloc_grant = alloc_req.
REQ-031 Reset SHALL override all same-cycle inputs, including mid-packet sends and credits.

Structure
REQ-032 NVCS derivation and flit-type constants SHALL come from const.v; CLogB2 SHALL come from math.v.
REQ-033 Per-VC FSM and counter SHALL be a sub-module output_vc_slice, generated NVCS times.
REQ-034 Round-robin selection and pointer SHALL stay in the parent.

Verification (VC_WIDTH=1, NCREDITS=4)
REQ-035 Reset, then alloc_req=1 for 3 cycles -> grants VC0, VC1, then alloc_grant=0; vc_idle 11 -> 10 -> 00.
REQ-036 VC0 active: 4 sends with no credits -> vc_credit_avail[0]=0; 5th send -> error=1 and count stays 0.
REQ-037 VC0 active: send head + tail, then 2 credits -> DRAIN after tail, IDLE on the 2nd credit edge, vc_idle[0]=1 one cycle later.
REQ-038 Tail send and credit on VC0 in the same cycle with count 3 -> count stays 3 and VC0 enters DRAIN.
REQ-039 Pointer=1 with VC1 busy and VC0 IDLE -> allocated_vc=0 (wrap) and pointer becomes 1.
REQ-040 Reset asserted mid-packet with VC1 in DRAIN and count 1 -> next cycle VC1 IDLE, count 4, error=0.
